// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the parametrised FIFO
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 6;
  localparam int FIFO_DEPTH      = 8;

  // Error codes reserved for the per-channel error register.
  localparam logic [1:0] FIFO_ERR_NONE = 2'd0;
  localparam logic [1:0] FIFO_ERR_OVF  = 2'd1;
  localparam logic [1:0] FIFO_ERR_UDF  = 2'd2;

  // Pointer width for a power-of-two depth.
  function automatic int fifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port RAM, synchronous write, registered read
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  localparam int ADDR_W    = fifo_addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write; the storage itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register only loads on an accepted pop, so it holds between pops
  // and never exposes an unwritten location after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with thresholds and error flags
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  localparam int ADDR_W    = fifo_addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_wr,
  input  logic                  fifo_rd,
  input  logic [ADDR_W:0]       al_full_th,
  input  logic [ADDR_W:0]       al_empty_th,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  al_full,
  output logic                  al_empty,
  output logic [ADDR_W:0]       count,
  output logic                  ovf,
  output logic                  udf,
  output logic                  err_sticky
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_cond;
  logic              udf_cond;

  // Status flags come straight from the registered count.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign al_full    = (count >= al_full_th);
  assign al_empty   = (count <= al_empty_th);

  // A full FIFO still takes a write when a read frees the slot the same edge;
  // an empty FIFO never lets a write fall through to the read port.
  assign wr_acc   = fifo_wr & (~fifo_full | fifo_rd);
  assign rd_acc   = fifo_rd & ~fifo_empty;
  assign ovf_cond = fifo_wr & ~wr_acc;
  assign udf_cond = fifo_rd & ~rd_acc;

  // Pointers wrap naturally at DEPTH; count tracks net push/pop.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc & ~rd_acc)      count <= count + 1'b1;
      else if (rd_acc & ~wr_acc) count <= count - 1'b1;
    end
  end

  // Read strobe and error pulses; a new error outranks err_clr.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      valid_out  <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      valid_out <= rd_acc;
      ovf       <= ovf_cond;
      udf       <= udf_cond;
      if (ovf_cond | udf_cond) err_sticky <= 1'b1;
      else if (err_clr)        err_sticky <= 1'b0;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (RESET),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       RESET;
  logic [5:0] data_in;
  logic       fifo_wr;
  logic       fifo_rd;
  logic [3:0] al_full_th;
  logic [3:0] al_empty_th;
  logic       err_clr;
  logic [5:0] data_out;
  logic       valid_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       al_full;
  logic       al_empty;
  logic [3:0] count;
  logic       ovf;
  logic       udf;
  logic       err_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_param #(.DATA_WIDTH(6), .DEPTH(8)) dut (
    .clk         (clk),
    .RESET       (RESET),
    .data_in     (data_in),
    .fifo_wr     (fifo_wr),
    .fifo_rd     (fifo_rd),
    .al_full_th  (al_full_th),
    .al_empty_th (al_empty_th),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .al_full     (al_full),
    .al_empty    (al_empty),
    .count       (count),
    .ovf         (ovf),
    .udf         (udf),
    .err_sticky  (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given requests; outputs are observed 1 time unit after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [5:0] din);
    fifo_wr = wr;
    fifo_rd = rd;
    data_in = din;
    @(posedge clk);
    #1;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    RESET       = 1'b1;
    data_in     = '0;
    fifo_wr     = 1'b0;
    fifo_rd     = 1'b0;
    al_full_th  = 4'd8;
    al_empty_th = 4'd0;
    err_clr     = 1'b0;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_errs", {29'd0, ovf, udf, err_sticky}, 32'd0);
    check("rst_al_full", 32'(al_full), 32'd0);
    check("rst_al_empty", 32'(al_empty), 32'd1);
    #9;
    RESET = 1'b0;
    @(posedge clk);
    #1;

    // Fill and drain in order.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 6'(i));
    check("fill_count", 32'(count), 32'd8);
    check("fill_full", 32'(fifo_full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 6'd0);
      check($sformatf("drain_valid_%0d", i), 32'(valid_out), 32'd1);
      check($sformatf("drain_data_%0d", i), 32'(data_out), 32'(i));
    end
    check("drain_empty", 32'(fifo_empty), 32'd1);
    cyc(1'b0, 1'b0, 6'd0);
    check("idle_valid", 32'(valid_out), 32'd0);
    check("idle_hold", 32'(data_out), 32'h08);

    // Overflow at full; 0x3F must never come back out.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 6'(i));
    cyc(1'b1, 1'b0, 6'h3F);
    check("ovf_pulse", 32'(ovf), 32'd1);
    check("ovf_sticky", 32'(err_sticky), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    cyc(1'b0, 1'b0, 6'd0);
    check("ovf_single", 32'(ovf), 32'd0);
    check("ovf_sticky_hold", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 6'd0);
    check("errclr", 32'(err_sticky), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 6'd0);
      check($sformatf("ovf_drain_%0d", i), 32'(data_out), 32'(i));
    end

    // Empty with simultaneous rd/wr: write lands, read rejected.
    cyc(1'b1, 1'b1, 6'h15);
    check("udf_pulse", 32'(udf), 32'd1);
    check("udf_count", 32'(count), 32'd1);
    check("udf_valid", 32'(valid_out), 32'd0);
    check("udf_sticky", 32'(err_sticky), 32'd1);
    cyc(1'b0, 1'b1, 6'd0);
    check("udf_readback", 32'(data_out), 32'h15);
    check("udf_rb_valid", 32'(valid_out), 32'd1);
    check("udf_single", 32'(udf), 32'd0);
    // Clear and a new underflow on the same edge: set wins.
    err_clr = 1'b1;
    cyc(1'b0, 1'b1, 6'd0);
    check("set_wins", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 6'd0);
    check("clr_after", 32'(err_sticky), 32'd0);

    // Full rd+wr streaming across pointer wrap.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 6'(i));
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b1, 6'(9 + k));
      check($sformatf("stream_data_%0d", k), 32'(data_out), 32'(1 + k));
      check($sformatf("stream_count_%0d", k), 32'(count), 32'd8);
      check($sformatf("stream_err_%0d", k), {30'd0, ovf, udf}, 32'd0);
    end
    for (int i = 13; i <= 20; i++) begin
      cyc(1'b0, 1'b1, 6'd0);
      check($sformatf("stream_tail_%0d", i), 32'(data_out), 32'(i));
    end
    check("stream_empty", 32'(fifo_empty), 32'd1);

    // Thresholds across every occupancy.
    al_full_th  = 4'd6;
    al_empty_th = 4'd2;
    for (int c = 0; c <= 8; c++) begin
      #1;
      check($sformatf("th_al_empty_%0d", c), 32'(al_empty), (c <= 2) ? 32'd1 : 32'd0);
      check($sformatf("th_al_full_%0d", c), 32'(al_full), (c >= 6) ? 32'd1 : 32'd0);
      if (c < 8) cyc(1'b1, 1'b0, 6'(c + 32));
    end
    al_empty_th = 4'd8;
    #1;
    check("th_empty_max", 32'(al_empty), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 6'd0);
    check("th_drain_last", 32'(data_out), 32'd39);
    al_full_th = 4'd0;
    #1;
    check("th_full_zero", 32'(al_full), 32'd1);
    al_full_th  = 4'd8;
    al_empty_th = 4'd0;

    // Asynchronous reset between edges at count 5 with a fresh pop showing.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 6'(16 + i));
    cyc(1'b0, 1'b1, 6'd0);
    check("pre_rst_count", 32'(count), 32'd5);
    check("pre_rst_valid", 32'(valid_out), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(fifo_empty), 32'd1);
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_dout", 32'(data_out), 32'd0);
    #1;
    RESET = 1'b0;
    cyc(1'b1, 1'b0, 6'h2A);
    check("post_rst_count", 32'(count), 32'd1);
    cyc(1'b0, 1'b1, 6'd0);
    check("post_rst_data", 32'(data_out), 32'h2A);
    check("post_rst_valid", 32'(valid_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
